// File: rtl/dma_stream_decoupler.sv
// Static-side decoupler between the partition's DMA stream and the PCIe DMA engine: registered 2-entry skid,
// drain/decouple/discard control and diagnostics counters. Optional drain timeout: DMA_DECOUPLER_TIMEOUT_EN.
module dma_stream_decoupler #(
    parameter int C_DATA_WIDTH    = 128,
    parameter int C_DRAIN_TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    decouple_req,
    output logic                    decouple_ack,
    input  logic [C_DATA_WIDTH-1:0] s_axis_dma_tdata,
    input  logic                    s_axis_dma_tlast,
    input  logic                    s_axis_dma_tvalid,
    output logic                    s_axis_dma_tready,
    output logic [C_DATA_WIDTH-1:0] m_axis_dma_tdata,
    output logic                    m_axis_dma_tlast,
    output logic                    m_axis_dma_tvalid,
    input  logic                    m_axis_dma_tready,
    output logic [31:0]             pkt_count,
    output logic [15:0]             drop_count,
    output logic                    drain_abort
);
    typedef enum logic [1:0] {ST_PASS, ST_DRAIN, ST_DECOUPLED} state_t;

    state_t                  state_reg, state_next;
    logic                    out_valid_reg, out_valid_next;
    logic [C_DATA_WIDTH-1:0] out_data_reg, out_data_next;
    logic                    out_last_reg, out_last_next;
    logic                    skid_valid_reg, skid_valid_next;
    logic [C_DATA_WIDTH-1:0] skid_data_reg, skid_data_next;
    logic                    skid_last_reg, skid_last_next;
    logic                    ready_reg, ready_next;
    logic                    in_pkt_reg, in_pkt_next;
    logic                    ack_reg, ack_next;
    logic [31:0]             pkt_count_reg, pkt_count_next;
    logic [15:0]             drop_count_reg, drop_count_next;
    logic                    abort_reg;

    logic                    s_hs, m_hs, push, empty_next, fire;
    logic [C_DATA_WIDTH-1:0] push_data;
    logic                    push_last;

    assign s_hs = s_axis_dma_tvalid && ready_reg;
    assign m_hs = out_valid_reg && m_axis_dma_tready;

`ifdef DMA_DECOUPLER_TIMEOUT_EN
    localparam int TW = $clog2(C_DRAIN_TIMEOUT + 1);
    logic [TW-1:0] timer_reg, timer_next;
    logic          drain_idle;

    assign drain_idle = (state_reg == ST_DRAIN) && in_pkt_reg && !s_hs;
    // Fire only when slot 2 is free so the synthetic tlast always has room in the buffer.
    assign fire = drain_idle && !skid_valid_reg && (timer_reg == TW'(C_DRAIN_TIMEOUT - 1));

    always_comb begin
        timer_next = '0;
        if (drain_idle && !fire) begin
            timer_next = (timer_reg == TW'(C_DRAIN_TIMEOUT - 1)) ? timer_reg : timer_reg + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_reg <= '0;
        end else begin
            timer_reg <= timer_next;
        end
    end
`else
    assign fire = 1'b0;
`endif

    // Beats accepted while decoupled are swallowed; everything else enters the skid buffer.
    assign push      = (s_hs && (state_reg != ST_DECOUPLED)) || fire;
    assign push_data = fire ? '0 : s_axis_dma_tdata;
    assign push_last = fire ? 1'b1 : s_axis_dma_tlast;

    always_comb begin
        out_valid_next  = out_valid_reg;
        out_data_next   = out_data_reg;
        out_last_next   = out_last_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;
        skid_last_next  = skid_last_reg;
        in_pkt_next     = in_pkt_reg;
        state_next      = state_reg;
        ready_next      = 1'b0;
        pkt_count_next  = pkt_count_reg;
        drop_count_next = drop_count_reg;

        if (s_hs) begin
            in_pkt_next = !s_axis_dma_tlast;
        end
        if (fire) begin
            in_pkt_next = 1'b0;
        end

        if (!out_valid_reg || m_hs) begin
            if (skid_valid_reg) begin
                out_valid_next  = 1'b1;
                out_data_next   = skid_data_reg;
                out_last_next   = skid_last_reg;
                skid_valid_next = push;
                if (push) begin
                    skid_data_next = push_data;
                    skid_last_next = push_last;
                end
            end else begin
                out_valid_next = push;
                if (push) begin
                    out_data_next = push_data;
                    out_last_next = push_last;
                end
            end
        end else if (push) begin
            skid_valid_next = 1'b1;
            skid_data_next  = push_data;
            skid_last_next  = push_last;
        end

        empty_next = !out_valid_next && !skid_valid_next;

        case (state_reg)
            ST_PASS:      if (decouple_req) state_next = ST_DRAIN;
            ST_DRAIN:     if (!in_pkt_next && empty_next) state_next = ST_DECOUPLED;
            ST_DECOUPLED: if (!decouple_req && !in_pkt_next) state_next = ST_PASS;
            default:      state_next = ST_PASS;
        endcase

        // s_tready is a register, so it is derived from next-cycle state and occupancy.
        case (state_next)
            ST_PASS:      ready_next = !skid_valid_next;
            ST_DRAIN:     ready_next = in_pkt_next && !skid_valid_next;
            ST_DECOUPLED: ready_next = 1'b1;
            default:      ready_next = 1'b0;
        endcase

        ack_next = (state_next == ST_DECOUPLED);

        if (m_hs && out_last_reg) begin
            pkt_count_next = pkt_count_reg + 32'd1;
        end
        if (s_hs && (state_reg == ST_DECOUPLED) && (drop_count_reg != 16'hFFFF)) begin
            drop_count_next = drop_count_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_PASS;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_last_reg   <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_last_reg  <= 1'b0;
            ready_reg      <= 1'b0;
            in_pkt_reg     <= 1'b0;
            ack_reg        <= 1'b0;
            pkt_count_reg  <= '0;
            drop_count_reg <= '0;
            abort_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            out_valid_reg  <= out_valid_next;
            out_data_reg   <= out_data_next;
            out_last_reg   <= out_last_next;
            skid_valid_reg <= skid_valid_next;
            skid_data_reg  <= skid_data_next;
            skid_last_reg  <= skid_last_next;
            ready_reg      <= ready_next;
            in_pkt_reg     <= in_pkt_next;
            ack_reg        <= ack_next;
            pkt_count_reg  <= pkt_count_next;
            drop_count_reg <= drop_count_next;
            abort_reg      <= fire;
        end
    end

    assign decouple_ack      = ack_reg;
    assign s_axis_dma_tready = ready_reg;
    assign m_axis_dma_tdata  = out_data_reg;
    assign m_axis_dma_tlast  = out_last_reg;
    assign m_axis_dma_tvalid = out_valid_reg;
    assign pkt_count         = pkt_count_reg;
    assign drop_count        = drop_count_reg;
    assign drain_abort       = abort_reg;

endmodule

// File: tb/tb_dma_stream_decoupler.sv
// Directed bench for dma_stream_decoupler: a cycle table for pass/backpressure/decouple plus hand sequences
// for drain, discard, saturation, re-entry, drain timeout (when DMA_DECOUPLER_TIMEOUT_EN is defined) and reset.
module tb_dma_stream_decoupler;
    localparam int DW  = 128;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          decouple_req;
    logic          decouple_ack;
    logic [DW-1:0] s_tdata;
    logic          s_tlast, s_tvalid, s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tlast, m_tvalid, m_tready;
    logic [31:0]   pkt_count;
    logic [15:0]   drop_count;
    logic          drain_abort;

    always #5 clk = ~clk;

    dma_stream_decoupler #(.C_DATA_WIDTH(DW), .C_DRAIN_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .decouple_req(decouple_req), .decouple_ack(decouple_ack),
        .s_axis_dma_tdata(s_tdata), .s_axis_dma_tlast(s_tlast),
        .s_axis_dma_tvalid(s_tvalid), .s_axis_dma_tready(s_tready),
        .m_axis_dma_tdata(m_tdata), .m_axis_dma_tlast(m_tlast),
        .m_axis_dma_tvalid(m_tvalid), .m_axis_dma_tready(m_tready),
        .pkt_count(pkt_count), .drop_count(drop_count), .drain_abort(drain_abort)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // m-side monitor: records delivered beats and flags data changing under backpressure.
    typedef struct packed {logic [DW-1:0] data; logic last;} beat_t;
    beat_t recv_q[$];
    beat_t exp_q[$];
    logic  prev_stall = 1'b0;
    beat_t prev_beat;
    int    stable_err = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!m_tvalid || m_tdata !== prev_beat.data || m_tlast !== prev_beat.last))
                stable_err++;
            if (m_tvalid && m_tready) recv_q.push_back('{m_tdata, m_tlast});
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = '{m_tdata, m_tlast};
        end
    end

    task automatic compare_queues(input string name);
        check({name, " beat count"}, 128'(recv_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < recv_q.size() && i < exp_q.size(); i++) begin
            check({name, " beat"}, {recv_q[i].data[126:0], recv_q[i].last}, {exp_q[i].data[126:0], exp_q[i].last});
        end
        recv_q.delete();
        exp_q.delete();
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic l);
        s_tvalid = v;
        s_tdata  = d;
        s_tlast  = l;
    endtask

    typedef struct {
        logic sv; logic [DW-1:0] sd; logic sl; logic mr; logic req;
        logic ev; logic [DW-1:0] ed; logic el; logic er; logic ea; logic [31:0] epkt; logic [15:0] edrop;
    } vec_t;

    localparam logic [DW-1:0] A1 = {4{32'hA1A1_0001}};
    localparam logic [DW-1:0] A2 = {4{32'hA2A2_0002}};
    localparam logic [DW-1:0] A3 = {4{32'hA3A3_0003}};
    localparam logic [DW-1:0] A4 = {4{32'hA4A4_0004}};
    localparam logic [DW-1:0] XX = {4{32'hDEAD_BEEF}};

    vec_t          vecs[15];
    logic [31:0]   exp_pkt;
    logic [15:0]   exp_drop;
    logic [DW-1:0] d;
    int            nbeats;
    int            k;
    logic          saw_ack, saw_abort;

    initial begin
        //          sv  sd  sl  mr  req  ev  ed  el  er  ea  pkt drop
        vecs[0]  = '{0, '0, 0, 1, 0,   0, '0, 0, 1, 0, 0, 0};
        vecs[1]  = '{1, A1, 0, 1, 0,   1, A1, 0, 1, 0, 0, 0};
        vecs[2]  = '{1, A2, 0, 1, 0,   1, A2, 0, 1, 0, 0, 0};
        vecs[3]  = '{1, A3, 0, 0, 0,   1, A2, 0, 0, 0, 0, 0};
        vecs[4]  = '{1, A4, 1, 0, 0,   1, A2, 0, 0, 0, 0, 0};
        vecs[5]  = '{1, A4, 1, 0, 0,   1, A2, 0, 0, 0, 0, 0};
        vecs[6]  = '{1, A4, 1, 0, 0,   1, A2, 0, 0, 0, 0, 0};
        vecs[7]  = '{1, A4, 1, 0, 0,   1, A2, 0, 0, 0, 0, 0};
        vecs[8]  = '{1, A4, 1, 1, 0,   1, A3, 0, 1, 0, 0, 0};
        vecs[9]  = '{1, A4, 1, 1, 0,   1, A4, 1, 1, 0, 0, 0};
        vecs[10] = '{0, '0, 0, 1, 0,   0, '0, 0, 1, 0, 1, 0};
        vecs[11] = '{0, '0, 0, 1, 1,   0, '0, 0, 0, 0, 1, 0};
        vecs[12] = '{0, '0, 0, 1, 1,   0, '0, 0, 1, 1, 1, 0};
        vecs[13] = '{1, XX, 1, 1, 1,   0, '0, 0, 1, 1, 1, 1};
        vecs[14] = '{0, '0, 0, 1, 0,   0, '0, 0, 1, 0, 1, 1};

        rst = 1'b1;
        decouple_req = 1'b0;
        m_tready = 1'b1;
        drive(1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset m_tvalid", 128'(m_tvalid), 128'(0));
        check("reset m_tdata", m_tdata, '0);
        check("reset s_tready", 128'(s_tready), 128'(0));
        check("reset ack", 128'(decouple_ack), 128'(0));
        check("reset counters", {pkt_count, drop_count, drain_abort}, '0);
        rst = 1'b0;

        // Cycle table: latency, 5-cycle backpressure, one-cycle DRAIN, one discard, return to PASS.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].sv, vecs[i].sd, vecs[i].sl);
            m_tready = vecs[i].mr;
            decouple_req = vecs[i].req;
            tick();
            $display("vec %0d: m_tvalid=%0b m_tlast=%0b s_tready=%0b ack=%0b pkt=%0d drop=%0d",
                     i, m_tvalid, m_tlast, s_tready, decouple_ack, pkt_count, drop_count);
            check($sformatf("vec%0d m_tvalid", i), 128'(m_tvalid), 128'(vecs[i].ev));
            if (vecs[i].ev) check($sformatf("vec%0d m_data", i), {m_tdata[126:0], m_tlast},
                                  {vecs[i].ed[126:0], vecs[i].el});
            check($sformatf("vec%0d s_tready", i), 128'(s_tready), 128'(vecs[i].er));
            check($sformatf("vec%0d ack", i), 128'(decouple_ack), 128'(vecs[i].ea));
            check($sformatf("vec%0d counters", i), {pkt_count, drop_count}, {vecs[i].epkt, vecs[i].edrop});
        end
        recv_q.delete();
        exp_pkt = 32'd1;
        exp_drop = 16'd1;

        // Back-to-back: 3 packets x 4 beats, each beat visible 1 cycle after its handshake.
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 4; b++) begin
                d = {4{8'hB0 + 8'(p), 8'(b), 16'h5A5A}};
                drive(1'b1, d, b == 3);
                exp_q.push_back('{d, b == 3});
                tick();
                $display("b2b p%0d b%0d: m_tvalid=%0b m_tdata=%0h s_tready=%0b", p, b, m_tvalid, m_tdata, s_tready);
                check("b2b latency data", {m_tvalid, m_tdata[126:0], m_tlast}, {1'b1, d[126:0], b == 3});
                check("b2b s_tready", 128'(s_tready), 128'(1));
            end
        end
        drive(1'b0, '0, 1'b0);
        tick();
        exp_pkt += 32'd3;
        check("b2b pkt_count", 128'(pkt_count), 128'(exp_pkt));
        compare_queues("b2b");

        // Mid-packet decouple: request on beat 2 of 6, the rest of the packet still drains out.
        for (int b = 0; b < 6; b++) begin
            d = {4{32'hC0DE_0000 + 32'(b)}};
            if (b == 1) decouple_req = 1'b1;
            drive(1'b1, d, b == 5);
            exp_q.push_back('{d, b == 5});
            tick();
            $display("drain b%0d: s_tready=%0b ack=%0b", b, s_tready, decouple_ack);
            check("drain s_tready", 128'(s_tready), 128'(b != 5));
            check("drain ack low", 128'(decouple_ack), 128'(0));
        end
        drive(1'b0, '0, 1'b0);
        check("drain tlast on m", 128'({m_tvalid, m_tlast}), 128'(2'b11));
        tick();
        $display("drain done: m_tvalid=%0b ack=%0b s_tready=%0b", m_tvalid, decouple_ack, s_tready);
        check("drain ack after tlast", 128'({decouple_ack, m_tvalid, s_tready}), 128'(3'b101));
        exp_pkt += 32'd1;
        check("drain pkt_count", 128'(pkt_count), 128'(exp_pkt));
        compare_queues("drain");

        // Discard: 10 beats while decoupled.
        for (int b = 0; b < 10; b++) begin
            drive(1'b1, {$urandom(), $urandom(), $urandom(), $urandom()}, b == 9);
            tick();
            check("discard m_tvalid", 128'(m_tvalid), 128'(0));
        end
        drive(1'b0, '0, 1'b0);
        tick();
        exp_drop += 16'd10;
        $display("discard: drop_count=%0d", drop_count);
        check("discard drop_count", 128'(drop_count), 128'(exp_drop));

        // Saturation: run drop_count up to 0xFFFE, then 5 more beats must stop at 0xFFFF.
        nbeats = 32'hFFFE - 32'(exp_drop);
        drive(1'b1, XX, 1'b1);
        repeat (nbeats) tick();
        drive(1'b0, '0, 1'b0);
        tick();
        $display("saturate: drop_count=%0h", drop_count);
        check("drop_count at FFFE", 128'(drop_count), 128'(16'hFFFE));
        drive(1'b1, XX, 1'b1);
        repeat (5) tick();
        drive(1'b0, '0, 1'b0);
        tick();
        $display("saturate: drop_count=%0h", drop_count);
        check("drop_count saturates", 128'(drop_count), 128'(16'hFFFF));

        // Re-entry mid-packet: release while the partition is mid-packet, discard through tlast.
        drive(1'b1, XX, 1'b0);
        tick();
        check("reentry ack held", 128'(decouple_ack), 128'(1));
        decouple_req = 1'b0;
        drive(1'b1, XX, 1'b0);
        tick();
        check("reentry still decoupled", 128'({decouple_ack, s_tready}), 128'(2'b11));
        drive(1'b1, XX, 1'b1);
        tick();
        $display("reentry: ack=%0b s_tready=%0b m_tvalid=%0b", decouple_ack, s_tready, m_tvalid);
        check("reentry back to pass", 128'({decouple_ack, s_tready, m_tvalid}), 128'(3'b010));
        for (int b = 0; b < 3; b++) begin
            d = {4{32'hF00D_0000 + 32'(b)}};
            drive(1'b1, d, b == 2);
            exp_q.push_back('{d, b == 2});
            tick();
        end
        drive(1'b0, '0, 1'b0);
        tick();
        exp_pkt += 32'd1;
        check("reentry pkt_count", 128'(pkt_count), 128'(exp_pkt));
        check("reentry drop_count", 128'(drop_count), 128'(16'hFFFF));
        compare_queues("reentry");

        // Partition stalls mid-packet in DRAIN.
        decouple_req = 1'b1;
        d = {4{32'h6060_0001}};
        drive(1'b1, d, 1'b0);
        exp_q.push_back('{d, 1'b0});
        tick();
        drive(1'b0, '0, 1'b0);
`ifdef DMA_DECOUPLER_TIMEOUT_EN
        k = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (drain_abort) begin
                k = c;
                break;
            end
        end
        $display("timeout: drain_abort after %0d idle cycles", k);
        check("timeout latency", 128'(k), 128'(TMO));
        check("timeout synthetic beat", {m_tvalid, m_tdata[126:0], m_tlast}, {1'b1, 127'd0, 1'b1});
        exp_q.push_back('{'0, 1'b1});
        tick();
        check("timeout abort pulse", 128'({drain_abort, decouple_ack}), 128'(2'b01));
        exp_pkt += 32'd1;
`else
        saw_ack = 1'b0;
        saw_abort = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            saw_ack |= decouple_ack;
            saw_abort |= drain_abort;
        end
        $display("no timeout: ack seen=%0b abort seen=%0b s_tready=%0b", saw_ack, saw_abort, s_tready);
        check("stall stays in drain", 128'({saw_ack, saw_abort, s_tready}), 128'(3'b001));
        d = {4{32'h6060_0002}};
        drive(1'b1, d, 1'b1);
        exp_q.push_back('{d, 1'b1});
        tick();
        drive(1'b0, '0, 1'b0);
        tick();
        check("stall then tlast decouples", 128'(decouple_ack), 128'(1));
        exp_pkt += 32'd1;
`endif
        decouple_req = 1'b0;
        tick();
        check("stall release ack", 128'(decouple_ack), 128'(0));
        check("stall pkt_count", 128'(pkt_count), 128'(exp_pkt));
        compare_queues("stall");
        check("m stable under backpressure", 128'(stable_err), 128'(0));

        // Asynchronous reset mid-packet with two beats buffered.
        m_tready = 1'b0;
        drive(1'b1, A1, 1'b0);
        tick();
        drive(1'b1, A2, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0);
        #2 rst = 1'b1;
        #1;
        $display("async reset: m_tvalid=%0b s_tready=%0b pkt=%0d drop=%0d", m_tvalid, s_tready, pkt_count, drop_count);
        check("async reset outputs", {m_tvalid, s_tready, decouple_ack, drain_abort, m_tlast}, '0);
        check("async reset data/counters", {m_tdata[79:0], pkt_count, drop_count}, '0);
        tick();
        rst = 1'b0;
        m_tready = 1'b1;
        recv_q.delete();
        saw_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            saw_ack |= m_tvalid;
        end
        check("no beat after reset", 128'({saw_ack, 32'(recv_q.size())}), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
